scalar_vector_sequencer: RTL and testbench
==========================================

# scalar_vector_sequencer

Control FSM that sequences the constant-times-vector datapath: an N-entry load/shift register feeding a pipelined multiplier, whose products are collected into a second shift register. It issues the parallel load, steps the input shifter once per element, and delays the output-shifter strobe by the multiplier's pipeline latency. It raises a one-cycle completion flag once all N products are captured. It sits beside the shifters and the multiplier inside the scalar-vector unit used by the pseudoinverse engine.

## Interface
- N, 4: vector length in elements; N ≥ 1.
- LAT, 1: multiplier pipeline latency in cycles, from operand presented to product valid; LAT ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; while low, all state and outputs are forced to reset values.
- start  in  1  request a new operation; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE without asserting flag.
- load  out  1  parallel-load strobe for the input shifter.
- shift_in  out  1  advance the input shifter; also marks an element issued to the multiplier.
- shift_out  out  1  shift the multiplier product into the output shifter.
- busy  out  1  high in every state except IDLE.
- flag  out  1  one-cycle completion pulse.
- idx  out  $clog2(N+1)  number of elements issued so far in the current operation.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: all strobes low. start=1 → LOAD.
- LOAD: load=1 for exactly one cycle. Clear issue_cnt, cap_cnt and the delay line. → RUN.
- RUN: shift_in=1 every cycle; issue_cnt increments. The cycle on which issue_cnt reaches N-1 is the last issue → DRAIN.
- Delay line: LAT-bit shift register; input is shift_in; shift_out = oldest bit. Products are therefore captured exactly LAT cycles after issue.
- cap_cnt increments on every shift_out, in both RUN and DRAIN.
- DRAIN: shift_in=0. When shift_out=1 and cap_cnt=N-1, the last capture has occurred → DONE.
- DONE: flag=1 for one cycle. → IDLE.
- idx = issue_cnt. It holds its final value N through DRAIN, DONE and IDLE, and is cleared in LOAD.
- start while busy is ignored; there is no queueing.
- abort=1 in any non-IDLE state: next state IDLE, delay line cleared, no flag, no further strobes from the next cycle on.
- abort takes priority over all other transitions. abort and start together in IDLE → stay in IDLE.
- Counters saturate logically at N; no wrap-around is permitted.

## Timing
- Reset values: load=0, shift_in=0, shift_out=0, busy=0, flag=0, idx=0, state=IDLE, delay line all zero.
- Reset assertion mid-operation takes effect immediately, without waiting for a clock edge. After release, the block waits in IDLE for a new start.
- With start sampled high at edge 0:
  - load is high in cycle 1.
  - shift_in is high in cycles 2 … N+1.
  - shift_out is high in cycles 2+LAT … N+1+LAT.
  - flag is high in cycle N+2+LAT.
  - busy is high in cycles 1 … N+2+LAT.
- Start-to-flag latency is N+LAT+2 cycles. The earliest next start is sampled in the cycle after flag.
- Exactly N shift_in pulses and N shift_out pulses per completed operation, each train contiguous.
- N=1: a single shift_in cycle; RUN goes to DRAIN immediately.

## Test plan
- N=4, LAT=1, one start pulse → load in cycle 1; shift_in in cycles 2–5; shift_out in cycles 3–6; flag in cycle 7 only; idx=4 afterwards.
- N=4, LAT=3 → shift_out in cycles 5–8; flag in cycle 9; 4 pulses on each strobe.
- start held high continuously → operations back to back, flag every N+LAT+3 cycles. Pulses on start during busy produce no extra load.
- abort in cycle 4 (N=4, LAT=1) → no strobes from cycle 5 on; busy=0 in cycle 5; flag never asserted. A following start yields a full, correct sequence.
- reset driven low mid-RUN, between clock edges → all outputs read 0 immediately. After release, idle until start; the next operation is correct.
- N=1, LAT=1 → load in cycle 1, shift_in in cycle 2, shift_out in cycle 3, flag in cycle 4.

Source files
------------

// File: rtl/scalar_vector_sequencer.sv
// rtl/scalar_vector_sequencer.sv - control FSM for the constant-times-vector datapath
//
// Sequences an N-entry input shifter feeding a LAT-cycle multiplier and the
// output shifter that collects the products.
//
// Parameters:
//   N    vector length in elements (N >= 1)
//   LAT  multiplier latency, operand presented to product valid (LAT >= 1)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request a new operation (sampled only when idle)
//   abort      synchronous cancel back to idle, no completion flag
//   load       one-cycle parallel-load strobe for the input shifter
//   shift_in   advance the input shifter / element issued to the multiplier
//   shift_out  capture a multiplier product into the output shifter
//   busy       high in every state except idle
//   flag       one-cycle completion pulse
//   idx        number of elements issued in the current operation
module scalar_vector_sequencer #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    output logic                     load,
    output logic                     shift_in,
    output logic                     shift_out,
    output logic                     busy,
    output logic                     flag,
    output logic [$clog2(N+1)-1:0]   idx
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   issue_cnt;
    logic [CW-1:0]   cap_cnt;
    // Bit i is an element issued i+1 cycles ago; the oldest bit marks a
    // product leaving the multiplier this cycle.
    logic [LAT-1:0]  dly;

    assign shift_out = dly[LAT-1];
    assign idx       = issue_cnt;

    // Outputs are registered: each transition sets the strobes that belong
    // to the state being entered, so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            dly       <= '0;
            load      <= 1'b0;
            shift_in  <= 1'b0;
            busy      <= 1'b0;
            flag      <= 1'b0;
        end else begin
            // Low bits of the concatenation keep {dly[LAT-2:0], shift_in}.
            dly      <= LAT'({dly, shift_in});
            load     <= 1'b0;
            shift_in <= 1'b0;
            flag     <= 1'b0;

            if (shift_out && (state == RUN || state == DRAIN) && cap_cnt != CNT_MAX) begin
                cap_cnt <= cap_cnt + 1'b1;
            end

            if (abort && state != IDLE) begin
                // Clearing the delay line stops in-flight captures at once.
                state <= IDLE;
                dly   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state     <= LOAD;
                            load      <= 1'b1;
                            busy      <= 1'b1;
                            issue_cnt <= '0;
                            cap_cnt   <= '0;
                            dly       <= '0;
                        end
                    end
                    LOAD: begin
                        state     <= RUN;
                        shift_in  <= 1'b1;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                        dly       <= '0;
                    end
                    RUN: begin
                        if (issue_cnt != CNT_MAX) begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                        // This cycle's issue is the last one when the count
                        // already shows N-1 elements out.
                        if (issue_cnt == LAST) begin
                            state <= DRAIN;
                        end else begin
                            shift_in <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (shift_out && cap_cnt == LAST) begin
                            state <= DONE;
                            flag  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scalar_vector_sequencer.sv
// tb/tb_scalar_vector_sequencer.sv - directed self-checking bench for scalar_vector_sequencer
module tb_scalar_vector_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;

    logic       load0, si0, so0, busy0, flag0;
    logic [2:0] idx0;
    logic       load1, si1, so1, busy1, flag1;
    logic [2:0] idx1;
    logic       load2, si2, so2, busy2, flag2;
    logic [0:0] idx2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    scalar_vector_sequencer #(.N(4), .LAT(1)) u_n4l1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load(load0), .shift_in(si0), .shift_out(so0),
        .busy(busy0), .flag(flag0), .idx(idx0)
    );

    scalar_vector_sequencer #(.N(4), .LAT(3)) u_n4l3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load(load1), .shift_in(si1), .shift_out(so1),
        .busy(busy1), .flag(flag1), .idx(idx1)
    );

    scalar_vector_sequencer #(.N(1), .LAT(1)) u_n1l1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .load(load2), .shift_in(si2), .shift_out(so2),
        .busy(busy2), .flag(flag2), .idx(idx2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected strobes for cycle c after start sampled at edge 0.
    task automatic chk_cycle(input string nm, input int n, input int lat, input int c,
                             input bit ab, input logic l, input logic si, input logic so,
                             input logic b, input logic f, input logic [7:0] ix);
        logic el, esi, eso, eb, ef;
        int   ei;
        el  = !ab && (c == 1);
        esi = !ab && (c >= 2) && (c <= n + 1);
        eso = !ab && (c >= 2 + lat) && (c <= n + 1 + lat);
        ef  = !ab && (c == n + 2 + lat);
        eb  = !ab && (c >= 1) && (c <= n + 2 + lat);
        check($sformatf("%s_c%0d_load", nm, c), {7'd0, l}, {7'd0, el});
        check($sformatf("%s_c%0d_shift_in", nm, c), {7'd0, si}, {7'd0, esi});
        check($sformatf("%s_c%0d_shift_out", nm, c), {7'd0, so}, {7'd0, eso});
        check($sformatf("%s_c%0d_busy", nm, c), {7'd0, b}, {7'd0, eb});
        check($sformatf("%s_c%0d_flag", nm, c), {7'd0, f}, {7'd0, ef});
        if (!ab && c >= 2) begin
            ei = (c - 2 > n) ? n : c - 2;
            check($sformatf("%s_c%0d_idx", nm, c), ix, 8'(ei));
        end
    endtask

    task automatic chk_all(input int c, input bit ab);
        chk_cycle("n4l1", 4, 1, c, ab, load0, si0, so0, busy0, flag0, 8'(idx0));
        chk_cycle("n4l3", 4, 3, c, ab, load1, si1, so1, busy1, flag1, 8'(idx1));
        chk_cycle("n1l1", 1, 1, c, ab, load2, si2, so2, busy2, flag2, 8'(idx2));
    endtask

    task automatic chk_quiet(input string tag, input bit check_idx);
        check({tag, "_outs_n4l1"}, {3'd0, load0, si0, so0, busy0, flag0}, 8'd0);
        check({tag, "_outs_n4l3"}, {3'd0, load1, si1, so1, busy1, flag1}, 8'd0);
        check({tag, "_outs_n1l1"}, {3'd0, load2, si2, so2, busy2, flag2}, 8'd0);
        if (check_idx) begin
            check({tag, "_idx_n4l1"}, 8'(idx0), 8'd0);
            check({tag, "_idx_n4l3"}, 8'(idx1), 8'd0);
            check({tag, "_idx_n1l1"}, 8'(idx2), 8'd0);
        end
    endtask

    // One start pulse, then cycles 1..ncyc checked; abort raised during cycle abort_c.
    task automatic op(input int ncyc, input int abort_c);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            chk_all(c, (abort_c > 0) && (c > abort_c));
            abort = (c == abort_c);
        end
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_quiet("reset", 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("post_reset_idle", 1'b1);

        // Plain operations on all three configurations
        op(12, 0);
        check("final_idx_n4l1", 8'(idx0), 8'd4);
        check("final_idx_n4l3", 8'(idx1), 8'd4);
        check("final_idx_n1l1", 8'(idx2), 8'd1);

        // start held high: back-to-back operations, one load per operation
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check($sformatf("b2b_c%0d_load_n4l1", c), {7'd0, load0}, {7'd0, ((c - 1) % 8) == 0});
            check($sformatf("b2b_c%0d_flag_n4l1", c), {7'd0, flag0}, {7'd0, (c >= 7) && ((c - 7) % 8 == 0)});
            check($sformatf("b2b_c%0d_load_n4l3", c), {7'd0, load1}, {7'd0, ((c - 1) % 10) == 0});
            check($sformatf("b2b_c%0d_flag_n4l3", c), {7'd0, flag1}, {7'd0, (c >= 9) && ((c - 9) % 10 == 0)});
            check($sformatf("b2b_c%0d_load_n1l1", c), {7'd0, load2}, {7'd0, ((c - 1) % 5) == 0});
            check($sformatf("b2b_c%0d_flag_n1l1", c), {7'd0, flag2}, {7'd0, (c >= 4) && ((c - 4) % 5 == 0)});
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk_quiet("b2b_settled", 1'b0);

        // Abort during cycle 4, then a full clean operation
        op(10, 4);
        repeat (2) @(negedge clk);
        op(12, 0);

        // Asynchronous reset between edges in mid-RUN
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_shift_in_n4l1", {7'd0, si0}, 8'd1);
        #2 reset = 1'b0;
        #1 chk_quiet("async_reset", 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_quiet("after_reset_release", 1'b1);
        op(12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
